// File: rtl/lock_ctrl_pkg.sv
// Shared types and register-map constants for the MMIO lock actuator.
// Pure declarations; no logic, no latency, no flow control.
package lock_ctrl_pkg;

    typedef enum logic [1:0] {
        LOCKED    = 2'd0,
        UNLOCKING = 2'd1,
        UNLOCKED  = 2'd2,
        LOCKING   = 2'd3
    } lock_state_t;

    localparam int CTRL_OFS   = 0;
    localparam int STATUS_OFS = 1;
    localparam int UNLOCK_BIT = 0;
    localparam int LOCK_BIT   = 1;

    function automatic logic [31:0] status_word(lock_state_t st, logic timer_run);
        logic moving;
        moving = (st == UNLOCKING) || (st == LOCKING);
        return {27'd0, timer_run, st, moving, (st == UNLOCKED)};
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo frame generator: free-running frame counter, width latched only at frame end.
// pwm_out registered (1 clock after counter); no backpressure, runs every clock.
module servo_pwm_gen #(
    parameter int PWM_PERIOD  = 1000000,
    parameter int PULSE_RESET = 50000,
    parameter int WIDTH_W     = $clog2(PWM_PERIOD) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH_W-1:0] target_width,
    output logic               pwm_out,
    output logic               frame_wrap
);

    localparam int CNT_W = $clog2(PWM_PERIOD);

    logic [CNT_W-1:0]   frame_cnt;
    logic [WIDTH_W-1:0] active_width;

    assign frame_wrap = (frame_cnt == CNT_W'(PWM_PERIOD - 1));

    // Width only changes on the frame boundary so a pulse is never truncated or stretched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt    <= '0;
            active_width <= WIDTH_W'(PULSE_RESET);
            pwm_out      <= 1'b0;
        end else begin
            frame_cnt <= frame_wrap ? '0 : frame_cnt + CNT_W'(1);
            if (frame_wrap)
                active_width <= target_width;
            pwm_out <= (WIDTH_W'(frame_cnt) < active_width);
        end
    end

endmodule

// File: rtl/mmio_lock_ctrl.sv
// Memory-mapped servo lock controller; CTRL at BASE_ADDR, STATUS at BASE_ADDR+1.
// Reads return one clock after the address (RAM timing); stores never stall.
// Optional AUTO_RELOCK_EN: relocks after RELOCK_CYCLES clocks in UNLOCKED.
module mmio_lock_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR      = 12'hFF0,
    parameter int          PWM_PERIOD     = 1000000,
    parameter int          PULSE_LOCKED   = 50000,
    parameter int          PULSE_UNLOCKED = 100000,
    parameter int          SETTLE_PERIODS = 25,
    parameter int          RELOCK_CYCLES  = 250000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] lock_q,
    output logic        lock_sel,
    output logic        pwm_out,
    output logic        unlocked
);

    localparam int          WIDTH_W     = $clog2(PWM_PERIOD) + 1;
    localparam int          SETTLE_W    = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [11:0] CTRL_ADDR   = BASE_ADDR + 12'(CTRL_OFS);
    localparam logic [11:0] STATUS_ADDR = BASE_ADDR + 12'(STATUS_OFS);

    lock_state_t         state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [WIDTH_W-1:0]  target_width;
    logic                settle_clr, settle_done, frame_wrap, moving;
    logic                ctrl_wr, unlock_req, lock_req, relock_done, timer_run;
    logic                unused_data;

    assign unused_data = ^data[31:2];
    assign ctrl_wr     = wren && (address_dmem == CTRL_ADDR);
    assign lock_req    = ctrl_wr && data[LOCK_BIT];
    assign unlock_req  = ctrl_wr && data[UNLOCK_BIT] && !data[LOCK_BIT];
    assign moving      = (state == UNLOCKING) || (state == LOCKING);
    assign settle_done = frame_wrap && (settle_cnt == SETTLE_W'(SETTLE_PERIODS - 1));
    assign unlocked    = (state == UNLOCKED);

`ifdef AUTO_RELOCK_EN
    localparam int RELOCK_W = $clog2(RELOCK_CYCLES);
    logic [RELOCK_W-1:0] relock_cnt;

    assign relock_done = (state == UNLOCKED) && !unlock_req &&
                         (relock_cnt == RELOCK_W'(RELOCK_CYCLES - 1));
    assign timer_run   = (state == UNLOCKED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            relock_cnt <= '0;
        else if ((state != UNLOCKED) || unlock_req || relock_done)
            relock_cnt <= '0;
        else
            relock_cnt <= relock_cnt + RELOCK_W'(1);
    end
`else
    localparam int unused_relock = RELOCK_CYCLES;
    assign relock_done = 1'b0;
    assign timer_run   = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        settle_clr = 1'b0;
        case (state)
            LOCKED: if (unlock_req) begin
                state_nxt  = UNLOCKING;
                settle_clr = 1'b1;
            end
            UNLOCKING: if (lock_req) begin
                state_nxt  = LOCKING;
                settle_clr = 1'b1;
            end else if (settle_done) begin
                state_nxt = UNLOCKED;
            end
            UNLOCKED: if (lock_req || relock_done) begin
                state_nxt  = LOCKING;
                settle_clr = 1'b1;
            end
            // Requests are deliberately ignored while relocking.
            LOCKING: if (settle_done) state_nxt = LOCKED;
            default: state_nxt = LOCKED;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= LOCKED;
            settle_cnt <= '0;
            lock_sel   <= 1'b0;
            lock_q     <= '0;
        end else begin
            state <= state_nxt;
            if (settle_clr)
                settle_cnt <= '0;
            else if (moving && frame_wrap)
                settle_cnt <= settle_done ? '0 : settle_cnt + SETTLE_W'(1);
            lock_sel <= (address_dmem == CTRL_ADDR) || (address_dmem == STATUS_ADDR);
            lock_q   <= (address_dmem == STATUS_ADDR) ? status_word(state, timer_run) : '0;
        end
    end

    assign target_width = (state == UNLOCKING || state == UNLOCKED) ?
                          WIDTH_W'(PULSE_UNLOCKED) : WIDTH_W'(PULSE_LOCKED);

    servo_pwm_gen #(
        .PWM_PERIOD  (PWM_PERIOD),
        .PULSE_RESET (PULSE_LOCKED),
        .WIDTH_W     (WIDTH_W)
    ) u_pwm (
        .clock        (clock),
        .reset        (reset),
        .target_width (target_width),
        .pwm_out      (pwm_out),
        .frame_wrap   (frame_wrap)
    );

endmodule

// File: tb/tb_mmio_lock_ctrl.sv
// Bench for mmio_lock_ctrl: random bus traffic around directed lock/unlock steps,
// every clock compared against a frame-arithmetic reference model.
module tb_mmio_lock_ctrl;

    localparam int          P    = 100;
    localparam int          PL   = 5;
    localparam int          PU   = 10;
    localparam int          SP   = 2;
    localparam int          RC   = 1000;
    localparam logic [11:0] BASE = 12'hFF0;
    localparam logic [11:0] STAT = 12'hFF1;

    logic        clock, reset, wren;
    logic [11:0] address_dmem;
    logic [31:0] data, lock_q;
    logic        lock_sel, pwm_out, unlocked;

    int errors = 0;
    int checks = 0;
    int n, m_st, m_aw, m_frames, m_deadline, hi_cnt, cnt;
    logic        e_pwm, e_sel;
    logic [31:0] e_q;

    mmio_lock_ctrl #(
        .BASE_ADDR(BASE), .PWM_PERIOD(P), .PULSE_LOCKED(PL), .PULSE_UNLOCKED(PU),
        .SETTLE_PERIODS(SP), .RELOCK_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
        .data(data), .lock_q(lock_q), .lock_sel(lock_sel), .pwm_out(pwm_out),
        .unlocked(unlocked)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // States: 0 locked, 1 unlocking, 2 unlocked, 3 locking.
    function automatic logic [31:0] m_status(input int st);
        int timer = 0;
`ifdef AUTO_RELOCK_EN
        timer = (st == 2) ? 1 : 0;
`endif
        return 32'(((st == 2) ? 1 : 0) + (((st == 1) || (st == 3)) ? 2 : 0) + 4 * st + 16 * timer);
    endfunction

    task automatic model_reset();
        m_st = 0; m_aw = PL; m_frames = 0; m_deadline = 0; n = 0;
    endtask

    task automatic model_edge();
        int fc;
        bit wrap, ctrl, unl, lk;
        fc    = n % P;
        wrap  = (fc == P - 1);
        e_pwm = (fc < m_aw);
        e_sel = (address_dmem == BASE) || (address_dmem == STAT);
        e_q   = (address_dmem == STAT) ? m_status(m_st) : 32'd0;
        ctrl  = wren && (address_dmem == BASE);
        unl   = ctrl && data[0] && !data[1];
        lk    = ctrl && data[1];
        if (wrap) m_aw = (m_st == 1 || m_st == 2) ? PU : PL;
        case (m_st)
            0: if (unl) begin m_st = 1; m_frames = SP; end
            1: if (lk) begin m_st = 3; m_frames = SP; end
               else if (wrap) begin
                   m_frames--;
                   if (m_frames == 0) begin m_st = 2; m_deadline = n + RC; end
               end
            2: if (lk) begin m_st = 3; m_frames = SP; end
`ifdef AUTO_RELOCK_EN
               else if (unl) m_deadline = n + RC;
               else if (n == m_deadline) begin m_st = 3; m_frames = SP; end
`endif
            default: if (wrap) begin
                m_frames--;
                if (m_frames == 0) m_st = 0;
            end
        endcase
        n++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("lock_sel", 32'(lock_sel), 32'(e_sel));
        chk("lock_q", lock_q, e_q);
        chk("unlocked", 32'(unlocked), 32'(m_st == 2));
        if (pwm_out) hi_cnt++;
        @(negedge clock);
    endtask

    task automatic bus_random();
        case ($urandom_range(0, 3))
            0: begin wren = 1'b0; address_dmem = STAT; end
            1: begin wren = 1'b0; address_dmem = BASE; data = $urandom; end
            2: begin wren = 1'($urandom_range(0, 1)); address_dmem = 12'($urandom_range(0, 12'hFEF)); data = $urandom; end
            default: begin wren = 1'b1; address_dmem = STAT; data = $urandom; end
        endcase
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin bus_random(); tick(); end
        wren = 1'b0;
    endtask

    task automatic write_ctrl(input logic [31:0] d);
        wren = 1'b1; address_dmem = BASE; data = d;
        tick();
        wren = 1'b0; address_dmem = 12'h000;
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        wren = 1'b0; address_dmem = STAT;
        tick();
        chk(tag, lock_q, exp);
        chk({tag, "_sel"}, 32'(lock_sel), 32'd1);
    endtask

    task automatic wait_unlocked(input string tag, input logic want, input int bound, output int k);
        k = 0;
        while (unlocked !== want && k < bound) begin bus_random(); tick(); k++; end
        wren = 1'b0;
        chk(tag, 32'(unlocked), 32'(want));
    endtask

    initial begin
        clock = 1'b0; reset = 1'b0; wren = 1'b0; address_dmem = 12'h000; data = 32'd0;
        #1;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_q", lock_q, 32'd0);
        chk("rst_sel", 32'(lock_sel), 32'd0);
        chk("rst_unlocked", 32'(unlocked), 32'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1; model_reset();

        // Idle after reset: 5-clock pulses, STATUS reads zero.
        hi_cnt = 0; idle(100); chk("locked_pulse", 32'(hi_cnt), 32'd5);
        idle(150);
        read_status("status_reset", 32'h0);

        // Unlock sequence.
        write_ctrl(32'h1);
        read_status("status_unlocking", 32'h6);
        wait_unlocked("unlock_done", 1'b1, 400, cnt);
`ifdef AUTO_RELOCK_EN
        read_status("status_unlocked", 32'h19);
`else
        read_status("status_unlocked", 32'h9);
`endif
        hi_cnt = 0; idle(100); chk("unlocked_pulse", 32'(hi_cnt), 32'd10);
        write_ctrl(32'h2);
        read_status("status_locking", 32'hE);
        idle(250);
        read_status("status_relocked", 32'h0);

        // Both bits set while locked: lock wins, nothing moves.
        write_ctrl(32'h3);
        read_status("status_both_bits", 32'h0);
        idle(200);
        hi_cnt = 0; idle(100); chk("both_bits_pulse", 32'(hi_cnt), 32'd5);

        // Abort mid-unlock, then unlock request ignored while locking.
        write_ctrl(32'h1);
        idle(30);
        write_ctrl(32'h2);
        read_status("status_abort", 32'hE);
        write_ctrl(32'h1);
        read_status("status_locking_ignore", 32'hE);
        idle(250);
        read_status("status_abort_done", 32'h0);

`ifdef AUTO_RELOCK_EN
        write_ctrl(32'h1);
        wait_unlocked("auto_unlock", 1'b1, 400, cnt);
        wait_unlocked("auto_relock", 1'b0, 2000, cnt);
        chk("relock_delay", 32'(cnt), 32'd1000);
        idle(250);
        read_status("status_auto_locked", 32'h0);
        write_ctrl(32'h1);
        wait_unlocked("restart_unlock", 1'b1, 400, cnt);
        idle(899);
        write_ctrl(32'h1);
        wait_unlocked("restart_relock", 1'b0, 2000, cnt);
        chk("relock_restart", 32'(cnt), 32'd1000);
        idle(250);
`else
        write_ctrl(32'h1);
        wait_unlocked("hold_unlock", 1'b1, 400, cnt);
        idle(1500);
        chk("unlocked_persists", 32'(unlocked), 32'd1);
        write_ctrl(32'h2);
        idle(250);
`endif
        read_status("status_before_reset", 32'h0);

        // Reset in the middle of an unlock.
        write_ctrl(32'h1);
        idle(30);
        reset = 1'b0;
        #1;
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        chk("midrst_q", lock_q, 32'd0);
        chk("midrst_sel", 32'(lock_sel), 32'd0);
        chk("midrst_unlocked", 32'(unlocked), 32'd0);
        repeat (3) @(negedge clock);
        chk("midrst_hold_pwm", 32'(pwm_out), 32'd0);
        reset = 1'b1; model_reset();
        hi_cnt = 0; idle(100); chk("post_reset_pulse", 32'(hi_cnt), 32'd5);
        read_status("status_post_reset", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_lock_ctrl.md
Name: mmio_lock_ctrl

Overview:
- Memory-mapped lock-actuator peripheral on the processor's data-memory bus, downstream of the CPU: it consumes the same wren / address_dmem / data signals that drive RAM.
- Decodes stores to a small register window and drives a hobby-servo PWM output that moves the lock bolt.
- Provides registered status readback, which the top level muxes over RAM q_dmem when lock_sel is high.
- The top level gates RAM wEn off for addresses inside the window.

Parameters:
BASE_ADDR, 12'hFF0, word address of CTRL register; STATUS at BASE_ADDR+1
PWM_PERIOD, 1000000, clocks per servo frame (20 ms at 50 MHz)
PULSE_LOCKED, 50000, high-time clocks for the locked position (1 ms)
PULSE_UNLOCKED, 100000, high-time clocks for the unlocked position (2 ms)
SETTLE_PERIODS, 25, PWM frames allowed for the bolt to travel
RELOCK_CYCLES, 250000000, clocks in UNLOCKED before auto-relock (AUTO_RELOCK_EN only)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
wren  in  1  processor data-memory write enable
address_dmem  in  12  data-memory word address
data  in  32  processor store data
lock_q  out  32  registered read data for the window
lock_sel  out  1  registered: previous-cycle address was in the window
pwm_out  out  1  servo control pulse, registered
unlocked  out  1  high only in UNLOCKED

Behaviour:
- Reset (reset low, asynchronous):
  - state=LOCKED; all counters 0; active pulse width=PULSE_LOCKED.
  - pwm_out=0, lock_q=0, lock_sel=0, unlocked=0.
- CTRL write: wren && address_dmem==BASE_ADDR.
  - data[0]=unlock request; data[1]=lock request.
  - Both bits set: lock wins.
  - Writes to BASE_ADDR+1 are ignored.
- Read path: one-cycle latency, matching RAM.
  - lock_sel <= address in {BASE_ADDR, BASE_ADDR+1}.
  - lock_q <= STATUS word when address==BASE_ADDR+1, else 0.
  - STATUS: [0] unlocked, [1] moving (UNLOCKING or LOCKING), [3:2] state code, [4] relock timer running, [31:5] 0.
- State codes: LOCKED=0, UNLOCKING=1, UNLOCKED=2, LOCKING=3.
- FSM transitions, evaluated each clock:
  - LOCKED: unlock request -> UNLOCKING (settle cnt cleared). Lock request: no-op.
  - UNLOCKING: lock request -> LOCKING (abort, settle cnt cleared). Else at the PWM frame wrap with settle cnt==SETTLE_PERIODS-1 -> UNLOCKED.
  - UNLOCKED: lock request -> LOCKING. Unlock request restarts the relock timer.
  - LOCKING: all requests ignored (fail-safe). Frame-wrap with settle cnt==SETTLE_PERIODS-1 -> LOCKED.
  - Settle cnt increments once per frame wrap while moving.
- PWM:
  - Frame counter runs free 0..PWM_PERIOD-1 and wraps to 0.
  - Target width: PULSE_UNLOCKED in UNLOCKING/UNLOCKED, else PULSE_LOCKED.
  - Active width loads the target only when the frame counter==PWM_PERIOD-1; no mid-frame glitch.
  - pwm_out <= (frame counter < active width).
- Widths: counters sized with $clog2 of their parameter. No counter exceeds its limit; all wrap explicitly.
- Reset mid-motion forces LOCKED with PULSE_LOCKED immediately; the bolt re-homes on the next frames.

Optional Feature:
- Macro AUTO_RELOCK_EN.
- Defined:
  - A relock timer counts clocks in UNLOCKED.
  - On reaching RELOCK_CYCLES-1 -> LOCKING.
  - Timer clears on entry to UNLOCKED and on an unlock request in UNLOCKED.
  - STATUS[4]=1 while counting.
- Undefined: no timer logic; UNLOCKED persists until a lock request; STATUS[4]=0.

Decomposition:
- Package lock_ctrl_pkg:
  - state enum constants LOCKED/UNLOCKING/UNLOCKED/LOCKING (2-bit).
  - CTRL/STATUS offset constants (0, 1).
  - CTRL bit indices (UNLOCK_BIT=0, LOCK_BIT=1).
- Sub-module servo_pwm_gen:
  - Contains the frame counter, frame-boundary width load and pwm_out register.
  - Inputs: target width. Outputs: pwm_out and a frame_wrap pulse.
  - The FSM uses frame_wrap to drive the settle counter.

Test Plan:
All scenarios use PWM_PERIOD=100, PULSE_LOCKED=5, PULSE_UNLOCKED=10, SETTLE_PERIODS=2, RELOCK_CYCLES=1000.
1. Reset release, no writes -> pwm_out high 5 of every 100 clocks; read BASE+1 returns 0 one cycle later with lock_sel=1.
2. Write 1 to BASE -> STATUS=32'h6 (UNLOCKING, moving). Pulse becomes 10 clocks from the next frame boundary. After 2 frame wraps STATUS=32'h9 (or 32'h19 with AUTO_RELOCK_EN) and unlocked=1.
3. Write 3 to BASE while LOCKED -> no transition, pulse stays 5 (lock wins).
4. Unlock, then write 2 during UNLOCKING -> LOCKING next clock; write 1 during LOCKING is ignored; LOCKED after 2 frames.
5. AUTO_RELOCK_EN: in UNLOCKED, wait 1000 clocks -> LOCKING. Rewriting 1 at clock 900 delays the transition by 900 clocks.
6. Assert reset for 3 clocks during UNLOCKING mid-frame -> all outputs 0 immediately; after release, a 5-clock pulse and STATUS=0.
